lstm_step_seq: RTL and testbench
================================

// Module: lstm_step_seq
// PURPOSE
//  Hardware timestep sequencer and initiator for the two-layer LSTM encoder (lstm1 -> lstm2).
//  - Accepts one input vector per valid/ready handshake.
//  - Issues start1, waits for done1, then issues start2 and waits for done2.
//  - Pulses capture strobes so the h/c state registers feed back into the next timestep.
//  - Presents the result on an output valid/ready stream.
//  - It is the control end of the start/done protocol the LSTM cells respond to. It holds no datapath vectors.
// PARAMETERS
//  STEP_W   10    width of step_idx (timestep counter, wraps)
//  TIMEOUT  4096  max cycles spent in WAIT1 or WAIT2 before error
// PORTS
//  clk        in   1       clock; all logic on rising edge
//  rst        in   1       synchronous reset, active-high
//  in_valid   in   1       input vector valid (x_in driven externally)
//  in_ready   out  1       sequencer can accept a timestep
//  seq_first  in   1       with input: first step of sequence, zero h/c state
//  seq_last   in   1       with input: last step of sequence
//  start1     out  1       one-cycle start pulse to lstm1
//  done1      in   1       lstm1 done (level)
//  start2     out  1       one-cycle start pulse to lstm2
//  done2      in   1       lstm2 done (level)
//  clr_state  out  1       one-cycle pulse: zero h1/c1/h2/c2 prev registers
//  cap1       out  1       one-cycle pulse: latch h1,c1 into h1_prev,c1_prev
//  cap2       out  1       one-cycle pulse: latch h2,c2 into h2_prev,c2_prev
//  out_valid  out  1       h2/c2 result valid, held until out_ready
//  out_ready  in   1       downstream accepts result
//  out_last   out  1       result belongs to seq_last step
//  step_idx   out  STEP_W  index of step being processed or presented
//  busy       out  1       high in any state except IDLE and ERR
//  err_timeout out 1       sticky: a done never arrived within TIMEOUT cycles
// BEHAVIOUR
//  Reset (rst=1 at an edge, any state): state=IDLE, step_idx=0, err_timeout=0, all other outputs 0.
//  - in_ready is 0 during the rst cycle and 1 from the following cycle.
//  - Reset mid-operation aborts the step silently; no cap/out pulse is emitted.
//  FSM states: IDLE, CLEAR, START1, WAIT1, START2, WAIT2, OUTPUT, ERR.
//  IDLE: in_ready=1.
//  - On in_valid: latch seq_first/seq_last.
//  - seq_first=1 -> CLEAR, and step_idx<=0; seq_first=0 -> START1.
//  CLEAR: clr_state=1 for exactly 1 cycle -> START1.
//  START1: start1=1 for exactly 1 cycle -> WAIT1; clear seen_low flag and timeout counter.
//  WAIT1: done1 is a level.
//  - seen_low sets on the first cycle done1=0.
//  - done1 is accepted only when done1=1 AND (seen_low=1 or done1=0 seen this cycle's past). A stale high done from the previous step is ignored.
//  - On accept: cap1=1 in the same cycle -> START2.
//  START2/WAIT2: identical to START1/WAIT1 using start2/done2.
//  - On accept: cap2=1 in the same cycle -> OUTPUT.
//  OUTPUT: out_valid=1 and out_last=latched seq_last, both held stable until out_ready=1.
//  - On the handshake cycle: step_idx <= step_idx+1 (wraps at 2^STEP_W) -> IDLE.
//  - out_valid drops the next cycle.
//  Timeout: counter counts WAIT1/WAIT2 cycles.
//  - Reaching TIMEOUT-1 without accept -> ERR.
//  - ERR: err_timeout=1, in_ready=0, all pulses 0. Left only by rst.
//  Minimum latency (seq_first=0, done low 1 cycle, then high):
//  - handshake at cycle 0; start1 @1; cap1 @3; start2 @4; cap2 @6; out_valid @7.
//  - seq_first=1 adds 1 cycle.
//  Exclusivity:
//  - At most one of clr_state/start1/start2/cap1/cap2 is high per cycle.
//  - start1 and start2 never overlap a WAIT state of the same cell.
// TESTING
//  1 Single step, seq_first=1: done1 rises 5 cycles after start1, done2 3 after start2 -> clr_state@1, start1@2, cap1@8, start2@9, cap2@13, out_valid@14; step_idx=0.
//  2 Back-to-back 3-step sequence with out_ready=1, done held high between steps -> stale done ignored; no cap before the low phase; step_idx 0,1,2; out_last only on step 2.
//  3 Backpressure: out_ready=0 for 10 cycles -> out_valid/out_last/step_idx stable; in_ready=0 throughout; exactly one step_idx increment.
//  4 done2 never asserted, TIMEOUT=16 -> ERR after 16 WAIT2 cycles; err_timeout=1 sticky; in_ready=0 until rst.
//  5 rst asserted during WAIT1 -> next cycle all outputs 0, step_idx=0; the following input restarts cleanly with no spurious cap1.
//  6 STEP_W=2, 5 steps -> step_idx 0,1,2,3,0 (wrap); seq_first on step 4 forces step_idx=0 and pulses clr_state.

Source files
------------

// File: rtl/lstm_step_seq_if.sv
// Input/output stream bundle of the LSTM timestep sequencer.
// slave faces the sequencer, master faces the source/sink.
interface lstm_step_seq_if #(
    parameter int STEP_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic              seq_first;
    logic              seq_last;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [STEP_W-1:0] step_idx;

    modport slave (
        input  in_valid, seq_first, seq_last, out_ready,
        output in_ready, out_valid, out_last, step_idx
    );

    modport master (
        output in_valid, seq_first, seq_last, out_ready,
        input  in_ready, out_valid, out_last, step_idx
    );
endinterface

// File: rtl/lstm_step_seq.sv
// Timestep sequencer for the two-layer LSTM encoder (lstm1 -> lstm2).
// Drives start/capture strobes and the result handshake.
module lstm_step_seq #(
    parameter int STEP_W  = 10,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    lstm_step_seq_if.slave    io,
    output logic              start1,
    input  logic              done1,
    output logic              start2,
    input  logic              done2,
    output logic              clr_state,
    output logic              cap1,
    output logic              cap2,
    output logic              busy,
    output logic              err_timeout
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, CLEAR, START1, WAIT1, START2, WAIT2, OUTPUT, ERR
    } state_t;

    state_t            state;
    state_t            nxt;
    logic [STEP_W-1:0] step_q;
    logic              last_q;
    logic              seen_low;
    logic [CW-1:0]     tcnt;
    logic              done_cur;
    logic              acc;

    // done is a level: only a rising edge after a seen low counts
    assign done_cur = (state == WAIT1) ? done1 : done2;
    assign acc      = done_cur && seen_low;
    assign io.step_idx = step_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            step_q   <= '0;
            last_q   <= 1'b0;
            seen_low <= 1'b0;
            tcnt     <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && io.in_valid) begin
                last_q <= io.seq_last;
                if (io.seq_first)
                    step_q <= '0;
            end
            if (state == OUTPUT && io.out_ready)
                step_q <= step_q + STEP_W'(1);
            if (state == START1 || state == START2) begin
                seen_low <= 1'b0;
                tcnt     <= '0;
            end else if (state == WAIT1 || state == WAIT2) begin
                if (!done_cur)
                    seen_low <= 1'b1;
                tcnt <= tcnt + CW'(1);
            end
        end
    end

    always_comb begin
        nxt          = state;
        io.in_ready  = 1'b0;
        io.out_valid = 1'b0;
        io.out_last  = 1'b0;
        start1       = 1'b0;
        start2       = 1'b0;
        clr_state    = 1'b0;
        cap1         = 1'b0;
        cap2         = 1'b0;
        err_timeout  = 1'b0;
        busy         = (state != IDLE) && (state != ERR);
        unique case (state)
            IDLE: begin
                io.in_ready = 1'b1;
                if (io.in_valid)
                    nxt = io.seq_first ? CLEAR : START1;
            end
            CLEAR: begin
                clr_state = 1'b1;
                nxt       = START1;
            end
            START1: begin
                start1 = 1'b1;
                nxt    = WAIT1;
            end
            WAIT1: begin
                if (acc) begin
                    cap1 = 1'b1;
                    nxt  = START2;
                end else if (tcnt == TLAST) begin
                    nxt = ERR;
                end
            end
            START2: begin
                start2 = 1'b1;
                nxt    = WAIT2;
            end
            WAIT2: begin
                if (acc) begin
                    cap2 = 1'b1;
                    nxt  = OUTPUT;
                end else if (tcnt == TLAST) begin
                    nxt = ERR;
                end
            end
            OUTPUT: begin
                io.out_valid = 1'b1;
                io.out_last  = last_q;
                if (io.out_ready)
                    nxt = IDLE;
            end
            ERR: err_timeout = 1'b1;
            default: nxt = IDLE;
        endcase
        // a reset cycle emits nothing, so an aborted step leaves no strobe
        if (rst) begin
            io.in_ready  = 1'b0;
            io.out_valid = 1'b0;
            io.out_last  = 1'b0;
            start1       = 1'b0;
            start2       = 1'b0;
            clr_state    = 1'b0;
            cap1         = 1'b0;
            cap2         = 1'b0;
            err_timeout  = 1'b0;
            busy         = 1'b0;
        end
    end
endmodule

// File: tb/tb_lstm_step_seq.sv
// Directed bench for lstm_step_seq with a scoreboard of expected results
// and a small lstm cell model answering start pulses with done levels.
module tb_lstm_step_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start1, start2, clr_state, cap1, cap2, busy, err_timeout;
    logic done1 = 1'b1;
    logic done2 = 1'b1;

    lstm_step_seq_if #(.STEP_W(2)) io ();

    lstm_step_seq #(.STEP_W(2), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .io(io.slave),
        .start1(start1), .done1(done1),
        .start2(start2), .done2(done2),
        .clr_state(clr_state), .cap1(cap1), .cap2(cap2),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] idx;
        logic       last;
    } exp_t;

    exp_t q[$];
    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int n_out = 0;
    int exp_out = 0;
    logic [1:0] m_idx = '0;

    int s1 = 0, lat1 = 1, s2 = 0, lat2 = 1;
    bit never2 = 0;
    int k1 = 0, k2 = 0;
    int t_hs = -100, t_start1 = -100, t_cap1 = -100;
    int t_start2 = -100, t_cap2 = -100, t_ov = -100;
    bit hs_first = 0;
    bit ov_prev = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // cell model: done held for s cycles, low for lat cycles, then high
    always @(posedge clk) begin
        #2;
        if (rst) k1 = 0;
        else if (t_start1 == cyc - 1) k1 = 1;
        else if (k1 > 0) k1++;
        if (k1 > 0)
            done1 = (k1 <= s1) ? 1'b1 : ((k1 <= s1 + lat1) ? 1'b0 : 1'b1);
        if (rst) k2 = 0;
        else if (t_start2 == cyc - 1) k2 = 1;
        else if (k2 > 0) k2++;
        if (k2 > 0)
            done2 = (k2 <= s2) ? 1'b1 :
                    (never2 ? 1'b0 : ((k2 <= s2 + lat2) ? 1'b0 : 1'b1));
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("excl", int'($countones({clr_state, start1, start2, cap1, cap2}) <= 1), 1);
            if (io.in_valid && io.in_ready) begin
                t_hs = cyc;
                hs_first = io.seq_first;
            end
            if (clr_state) begin
                chk("clr_at", cyc - t_hs, 1);
                chk("clr_first", int'(hs_first), 1);
            end
            if (start1) begin
                t_start1 = cyc;
                chk("start1_lat", cyc - t_hs, hs_first ? 2 : 1);
            end
            if (cap1) begin
                t_cap1 = cyc;
                chk("cap1_gap", cyc - t_start1, s1 + lat1 + 1);
            end
            if (start2) begin
                t_start2 = cyc;
                chk("start2_gap", cyc - t_cap1, 1);
            end
            if (cap2) begin
                t_cap2 = cyc;
                chk("cap2_gap", cyc - t_start2, s2 + lat2 + 1);
            end
            if (io.out_valid && !ov_prev) begin
                t_ov = cyc;
                chk("ov_gap", cyc - t_cap2, 1);
            end
            if (io.out_valid)
                chk("inrdy_during_out", int'(io.in_ready), 0);
            if (io.out_valid && io.out_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    chk("sb_empty", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("out_idx", int'(io.step_idx), int'(e.idx));
                    chk("out_last", int'(io.out_last), int'(e.last));
                end
            end
        end
        ov_prev = io.out_valid;
    end

    task automatic send(input bit f, input bit l);
        @(posedge clk);
        #1;
        io.in_valid = 1'b1;
        io.seq_first = f;
        io.seq_last = l;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (io.in_ready) break;
        end
        if (!io.in_ready) chk("send_timeout", 0, 1);
        if (f) m_idx = '0;
        q.push_back('{m_idx, l});
        m_idx = m_idx + 2'd1;
        exp_out++;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        io.seq_first = 1'b0;
        io.seq_last = 1'b0;
    endtask

    task automatic wait_all();
        for (int n = 0; n < 1000; n++) begin
            if (n_out >= exp_out) break;
            @(negedge clk);
        end
        chk("out_count", n_out, exp_out);
    endtask

    task automatic pulse_rst();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        m_idx = '0;
        exp_out = n_out;
    endtask

    initial begin
        io.in_valid = 1'b0;
        io.seq_first = 1'b0;
        io.seq_last = 1'b0;
        io.out_ready = 1'b1;
        @(negedge clk);
        chk("rdy_in_rst", int'(io.in_ready), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rdy", int'(io.in_ready), 1);
        chk("rst_idx", int'(io.step_idx), 0);
        chk("rst_err", int'(err_timeout), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ov", int'(io.out_valid), 0);

        // single step with clear, done1 after 5, done2 after 3
        s1 = 0; lat1 = 5; s2 = 0; lat2 = 3;
        send(1, 0);
        wait_all();
        chk("t1_total_lat", t_ov - t_hs, 14);

        // minimum latency step
        lat1 = 1; lat2 = 1;
        send(0, 0);
        wait_all();
        chk("min_lat", t_ov - t_hs, 7);

        // back-to-back sequence with stale high done
        s1 = 2; s2 = 2;
        send(1, 0);
        send(0, 0);
        send(0, 1);
        wait_all();

        // backpressure
        s1 = 0; s2 = 0;
        io.out_ready = 1'b0;
        send(0, 0);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (io.out_valid) break;
        end
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("bp_ov", int'(io.out_valid), 1);
            chk("bp_idx", int'(io.step_idx), int'(q[0].idx));
            chk("bp_last", int'(io.out_last), 0);
            chk("bp_inrdy", int'(io.in_ready), 0);
        end
        @(posedge clk);
        #1 io.out_ready = 1'b1;
        wait_all();
        send(0, 1);
        wait_all();

        // timeout in WAIT2
        never2 = 1;
        send(0, 0);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (err_timeout) break;
        end
        chk("to_err", int'(err_timeout), 1);
        chk("to_cycles", cyc - t_start2, 17);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("err_sticky", int'(err_timeout), 1);
            chk("err_inrdy", int'(io.in_ready), 0);
            chk("err_busy", int'(busy), 0);
        end
        never2 = 0;
        pulse_rst();
        @(negedge clk);
        chk("post_err_err", int'(err_timeout), 0);
        chk("post_err_rdy", int'(io.in_ready), 1);

        // reset during WAIT1
        lat1 = 8;
        send(0, 0);
        repeat (4) @(negedge clk);
        chk("in_wait1_busy", int'(busy), 1);
        pulse_rst();
        @(negedge clk);
        chk("abort_out", int'({start1, start2, cap1, cap2, clr_state, io.out_valid}), 0);
        chk("abort_idx", int'(io.step_idx), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_rdy", int'(io.in_ready), 1);
        lat1 = 1;
        send(0, 1);
        wait_all();

        // step_idx wrap and seq_first forcing zero
        send(1, 0);
        send(0, 0);
        send(0, 0);
        send(0, 0);
        send(0, 0);
        send(0, 0);
        send(1, 1);
        wait_all();
        @(negedge clk);
        chk("final_idx", int'(io.step_idx), 1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
